// File: rtl/neuron_acc_ctrl_pkg.sv
// Shared definitions for the neuron accumulator controller: FSM encoding,
// default product-pipeline latency and the address-width helper.
package neuron_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEFAULT_MAC_LAT = 3;

  // ceil(log2(value)), never below 1 so a length-1 configuration still gets a bit.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/neuron_acc_ctrl_delay.sv
// Fixed-depth shift register with synchronous reset; carries {last, en}
// alongside the weight-ROM/multiplier pipeline.
module sig_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is reset, unlike a data RAM: a stale en/last left in
  // flight across a reset would corrupt the first post-reset vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Sequencer for one neuron: issues samples with weight addresses, drives the
// accumulator en/last in step with the product pipeline and buffers the result.
module neuron_acc_ctrl
  import neuron_acc_ctrl_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int MAX_LEN    = 256,
  parameter int MAC_LAT    = DEFAULT_MAC_LAT,
  localparam int ADDR_W    = clog2_min1(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W:0]       cfg_len,
  input  logic [DIN_WIDTH-1:0]  s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DIN_WIDTH-1:0]  mac_x,
  output logic                  mac_issue,
  output logic [ADDR_W-1:0]     w_addr,
  output logic                  acc_en,
  output logic                  acc_last,
  input  logic [DOUT_WIDTH-1:0] acc_dout,
  input  logic                  acc_dout_valid,
  output logic [DOUT_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_cfg,
  output logic                  err_len
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DR_W  = clog2_min1(MAC_LAT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_V     = LEN_W'(1);
  localparam logic [DR_W-1:0]  DRAIN_MIN = DR_W'(MAC_LAT);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [DR_W-1:0]         drain_q, drain_d;
  logic [DOUT_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    err_cfg_q, err_cfg_d;
  logic                    err_len_q, err_len_d;
  logic                    rst_hold_q, rst_hold_d;

  logic                    ready_c;
  logic                    issue;
  logic                    is_final;
  logic                    cfg_ok;
  logic [LEN_W-1:0]        eff_len;
  logic [1:0]              dl_in;
  logic [1:0]              dl_out;

  assign cfg_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
  assign eff_len = cfg_ok ? cfg_len : MAX_LEN_V;

  // The cycle right after a reset never accepts a sample.
  assign rst_hold_d = rst;

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: ready_c = ~m_valid_q | m_ready;
      ST_RUN:  ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
    ready_c = ready_c & ~rst_hold_q;
  end

  assign issue = s_valid & ready_c;

  always_comb begin
    is_final = 1'b0;
    if (state_q == ST_IDLE) begin
      is_final = (eff_len == ONE_V);
    end else if (state_q == ST_RUN) begin
      is_final = (count_q == (len_q - ONE_V));
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    drain_d   = drain_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_ready;
    err_cfg_d = err_cfg_q;
    err_len_d = err_len_q;

    if (issue && (s_last != is_final)) begin
      err_len_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          len_d = eff_len;
          if (!cfg_ok) err_cfg_d = 1'b1;
          if (is_final) begin
            state_d = ST_DRAIN;
            count_d = '0;
            drain_d = '0;
          end else begin
            state_d = ST_RUN;
            count_d = ONE_V;
          end
        end
      end

      ST_RUN: begin
        if (issue) begin
          if (is_final) begin
            state_d = ST_DRAIN;
            count_d = '0;
            drain_d = '0;
          end else begin
            count_d = count_q + ONE_V;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_q != DRAIN_MIN) begin
          drain_d = drain_q + DR_W'(1);
        end
        // Results before the last product can have reached the accumulator are not ours.
        if (acc_dout_valid && (drain_q == DRAIN_MIN)) begin
          m_data_d  = acc_dout;
          m_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      drain_q    <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_len_q  <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      err_cfg_q  <= err_cfg_d;
      err_len_q  <= err_len_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  // The final sample travels as last with en low, matching the accumulator protocol.
  assign dl_in = {issue & is_final, issue & ~is_final};

  sig_delay_line #(
    .WIDTH (2),
    .DEPTH (MAC_LAT)
  ) u_en_last_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign acc_en    = dl_out[0];
  assign acc_last  = dl_out[1];
  assign s_ready   = ready_c;
  assign mac_x     = s_data;
  assign mac_issue = issue;
  assign w_addr    = count_q[ADDR_W-1:0];
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_cfg   = err_cfg_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Self-checking bench for neuron_acc_ctrl with a weight-ROM/multiplier pipeline
// and signed accumulator modelled around it.
module tb_neuron_acc_ctrl;

  localparam int DIN_W   = 16;
  localparam int DOUT_W  = 32;
  localparam int MAX_LEN = 256;
  localparam int MAC_LAT = 3;
  localparam int ADDR_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [ADDR_W:0]          cfg_len;
  logic [DIN_W-1:0]         s_data;
  logic                     s_valid;
  logic                     s_last;
  logic                     s_ready;
  logic [DIN_W-1:0]         mac_x;
  logic                     mac_issue;
  logic [ADDR_W-1:0]        w_addr;
  logic                     acc_en;
  logic                     acc_last;
  logic signed [DOUT_W-1:0] acc_dout;
  logic                     acc_dout_valid;
  logic [DOUT_W-1:0]        m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     busy;
  logic                     err_cfg;
  logic                     err_len;

  always #5 clk = ~clk;

  neuron_acc_ctrl #(
    .DIN_WIDTH  (DIN_W),
    .DOUT_WIDTH (DOUT_W),
    .MAX_LEN    (MAX_LEN),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_len        (cfg_len),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mac_x          (mac_x),
    .mac_issue      (mac_issue),
    .w_addr         (w_addr),
    .acc_en         (acc_en),
    .acc_last       (acc_last),
    .acc_dout       (acc_dout),
    .acc_dout_valid (acc_dout_valid),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .busy           (busy),
    .err_cfg        (err_cfg),
    .err_len        (err_len)
  );

  // Datapath model: ROM + multiplier as a MAC_LAT-deep product pipeline, then the accumulator.
  int                       w_mem [0:MAX_LEN-1];
  logic signed [DOUT_W-1:0] prod_pipe [0:MAC_LAT-1];
  logic signed [DOUT_W-1:0] acc_sum;

  always @(posedge clk) begin
    prod_pipe[0] <= $signed(mac_x) * w_mem[w_addr];
    for (int i = 1; i < MAC_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
    if (rst) begin
      acc_sum        <= '0;
      acc_dout       <= '0;
      acc_dout_valid <= 1'b0;
    end else begin
      acc_dout_valid <= 1'b0;
      if (acc_en) acc_sum <= acc_sum + prod_pipe[MAC_LAT-1];
      if (acc_last) begin
        acc_dout       <= acc_sum + prod_pipe[MAC_LAT-1];
        acc_dout_valid <= 1'b1;
        acc_sum        <= '0;
      end
    end
  end

  // Cycle counter and en/last monitor.
  int cyc = 0;
  int en_total = 0;
  int last_total = 0;
  int overlap_total = 0;
  int last_cyc = 0;
  int en_log [0:8191];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (acc_en) begin
      en_log[en_total % 8192] <= cyc;
      en_total <= en_total + 1;
    end
    if (acc_last) begin
      last_cyc   <= cyc;
      last_total <= last_total + 1;
      if (acc_en) overlap_total <= overlap_total + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int hs_cyc = 0;
  int x_buf [0:MAX_LEN-1];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_sample(input int x, input bit last, input int idx, input string name);
    bit done;
    done    = 1'b0;
    s_data  = x[DIN_W-1:0];
    s_valid = 1'b1;
    s_last  = last;
    for (int k = 0; k < 1000 && !done; k++) begin
      #1;
      if (s_ready) begin
        check({name, " w_addr"}, w_addr, idx);
        check({name, " mac_issue"}, mac_issue, 1);
        hs_cyc = cyc;
        done   = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check({name, " s_ready timeout"}, 0, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input int n, input int gap, input int last_pos, input string name);
    for (int i = 0; i < n; i++) begin
      send_sample(x_buf[i], (i == last_pos), i, name);
      if (i < n - 1) begin
        repeat (gap) begin
          #1;
          check({name, " w_addr held"}, w_addr, i + 1);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_result(input int exp, input int hold, input string name);
    bit got;
    got     = 1'b0;
    m_ready = (hold == 0);
    for (int k = 0; k < 3000 && !got; k++) begin
      #1;
      if (m_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check({name, " m_valid timeout"}, 0, 1);
    end else begin
      check({name, " m_data"}, $signed(m_data), exp);
      repeat (hold) begin
        @(negedge clk);
        #1;
        check({name, " m_valid held"}, m_valid, 1);
        check({name, " m_data held"}, $signed(m_data), exp);
      end
      m_ready = 1'b1;
      @(negedge clk);
      #1;
      check({name, " m_valid pop"}, m_valid, 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    s_data  = 16'h1234;
    s_valid = 1'b1;
    #1;
    check({name, " s_ready"}, s_ready, 0);
    check({name, " mac_issue"}, mac_issue, 0);
    check({name, " mac_x"}, mac_x, 16'h1234);
    check({name, " w_addr"}, w_addr, 0);
    check({name, " acc_en"}, acc_en, 0);
    check({name, " acc_last"}, acc_last, 0);
    check({name, " m_data"}, m_data, 0);
    check({name, " m_valid"}, m_valid, 0);
    check({name, " busy"}, busy, 0);
    check({name, " err_cfg"}, err_cfg, 0);
    check({name, " err_len"}, err_len, 0);
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int cfg_len;
    int n;
    int x0, x1, x2, x3;
    int w;
    int gap;
    int exp_sum;
    int exp_en;
  } row_t;

  task automatic run_row(input row_t r, input string name);
    int en0, last0, ov0, fin;
    cfg_len = r.cfg_len[ADDR_W:0];
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = r.w;
    x_buf[0] = r.x0; x_buf[1] = r.x1; x_buf[2] = r.x2; x_buf[3] = r.x3;
    en0   = en_total;
    last0 = last_total;
    ov0   = overlap_total;
    send_vec(r.n, r.gap, r.n - 1, name);
    fin = hs_cyc;
    wait_result(r.exp_sum, 0, name);
    check({name, " acc_en count"}, en_total - en0, r.exp_en);
    check({name, " acc_last count"}, last_total - last0, 1);
    check({name, " acc_last latency"}, last_cyc - fin, MAC_LAT);
    check({name, " last with en"}, overlap_total - ov0, 0);
    for (int k = 0; k + 1 < r.exp_en; k++) begin
      check({name, " en spacing"}, en_log[(en0 + k + 1) % 8192] - en_log[(en0 + k) % 8192],
            r.gap + 1);
    end
    check({name, " err_len"}, err_len, 0);
    check({name, " err_cfg"}, err_cfg, 0);
  endtask

  row_t rows [4];

  initial begin
    int en0, last0, exp_sum, len, gap, hold;
    bit got;
    logic signed [DIN_W-1:0] xs;

    rows[0] = '{cfg_len: 4, n: 4, x0: 1,   x1: 2,    x2: 3,  x3: 4, w: 1,  gap: 0, exp_sum: 10,  exp_en: 3};
    rows[1] = '{cfg_len: 4, n: 4, x0: 1,   x1: 2,    x2: 3,  x3: 4, w: 1,  gap: 2, exp_sum: 10,  exp_en: 3};
    rows[2] = '{cfg_len: 1, n: 1, x0: -3,  x1: 0,    x2: 0,  x3: 0, w: 7,  gap: 0, exp_sum: -21, exp_en: 0};
    rows[3] = '{cfg_len: 3, n: 3, x0: 100, x1: -200, x2: 50, x3: 0, w: -3, gap: 1, exp_sum: 150, exp_en: 2};

    rst     = 1'b1;
    cfg_len = '0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = 1;
    repeat (3) @(negedge clk);
    do_reset("reset");

    for (int r = 0; r < 4; r++) run_row(rows[r], $sformatf("row%0d", r));

    // Back-pressure: result held while a new vector waits, then pop and start together.
    m_ready = 1'b0;
    cfg_len = 4;
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = 1;
    for (int i = 0; i < 4; i++) x_buf[i] = i + 1;
    send_vec(4, 0, 3, "bp");
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (m_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) check("bp m_valid timeout", 0, 1);
    check("bp m_data", $signed(m_data), 10);
    @(negedge clk);
    for (int i = 0; i < MAX_LEN; i++) w_mem[i] = 2;
    cfg_len = 2;
    s_data  = 16'd5;
    s_valid = 1'b1;
    s_last  = 1'b0;
    en0     = en_total;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("bp hold m_valid", m_valid, 1);
      check("bp hold m_data", $signed(m_data), 10);
      check("bp hold s_ready", s_ready, 0);
      check("bp hold mac_issue", mac_issue, 0);
      @(negedge clk);
    end
    check("bp hold acc_en", en_total - en0, 0);
    m_ready = 1'b1;
    send_sample(5, 1'b0, 0, "bp2");
    #1;
    check("bp2 popped", m_valid, 0);
    @(negedge clk);
    send_sample(6, 1'b1, 1, "bp2");
    wait_result(22, 0, "bp2");

    // Illegal cfg_len falls back to MAX_LEN; then a misplaced s_last.
    cfg_len = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mem[i] = 1;
      x_buf[i] = 1;
    end
    send_vec(MAX_LEN, 0, MAX_LEN - 1, "cfg0");
    wait_result(256, 0, "cfg0");
    check("cfg0 err_cfg", err_cfg, 1);
    check("cfg0 err_len", err_len, 0);
    cfg_len = 4;
    for (int i = 0; i < 4; i++) x_buf[i] = i + 1;
    last0 = last_total;
    send_vec(4, 0, 2, "lenerr");
    wait_result(10, 0, "lenerr");
    check("lenerr err_len", err_len, 1);
    check("lenerr err_cfg", err_cfg, 1);
    check("lenerr acc_last count", last_total - last0, 1);

    // Reset mid-vector, then a fresh vector containing only post-reset samples.
    cfg_len = 4;
    for (int i = 0; i < 4; i++) x_buf[i] = 100;
    send_vec(2, 0, 3, "midrst");
    do_reset("midrst reset");
    cfg_len = 3;
    for (int i = 0; i < 3; i++) x_buf[i] = 1;
    send_vec(3, 0, 2, "postrst");
    wait_result(3, 0, "postrst");

    // Randomised vectors against a plain dot-product model.
    for (int v = 0; v < 12; v++) begin
      len     = $urandom_range(1, 10);
      gap     = $urandom_range(0, 2);
      hold    = $urandom_range(0, 3);
      cfg_len = len[ADDR_W:0];
      exp_sum = 0;
      for (int i = 0; i < len; i++) begin
        xs       = DIN_W'($urandom);
        x_buf[i] = xs;
        w_mem[i] = int'($urandom_range(0, 2000)) - 1000;
        exp_sum += x_buf[i] * w_mem[i];
      end
      en0   = en_total;
      last0 = last_total;
      send_vec(len, gap, len - 1, $sformatf("rnd%0d", v));
      wait_result(exp_sum, hold, $sformatf("rnd%0d", v));
      check($sformatf("rnd%0d acc_en count", v), en_total - en0, len - 1);
      check($sformatf("rnd%0d acc_last count", v), last_total - last0, 1);
    end
    check("final err_len", err_len, 0);
    check("final err_cfg", err_cfg, 0);
    check("final busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
